// File: rtl/conv2_pe_ctrl.sv
// Sequencer for one conv-layer-2 PE chain: loads per-PE weight words, streams one ifmap row, drains and tags psums.
// Optional build macro CONV2_PE_CTRL_PERF_EN adds busy-cycle and stall-cycle performance counters.
module conv2_pe_ctrl #(
  parameter int IFMAP_W = 28,
  parameter int KERNEL  = 3,
  parameter int PE_ROWS = 3,
  parameter int LAT     = 4,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        w_valid,
  input  logic [11:0] w_data,
  output logic        w_ready,
  output logic        filt_wr,
  output logic [1:0]  filt_idx,
  output logic [11:0] filt_data,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        pe_en,
  output logic [7:0]  pe_ifmap,
  input  logic [13:0] psum_in,
  output logic        m_valid,
  output logic [13:0] m_data,
  input  logic        m_ready
`ifdef CONV2_PE_CTRL_PERF_EN
  ,
  output logic [15:0] perf_cycles,
  output logic [15:0] perf_stalls
`endif
);

  localparam int OUT_W = IFMAP_W - KERNEL + 1;
  localparam int WC_W  = $clog2(PE_ROWS + 1);

  localparam logic [WC_W-1:0]  W_LAST      = WC_W'(PE_ROWS);
  localparam logic [CNT_W-1:0] COL_LAST_IN = CNT_W'(IFMAP_W - 1);
  localparam logic [CNT_W-1:0] COL_FIRST   = CNT_W'(LAT);
  localparam logic [CNT_W-1:0] COL_LAST    = CNT_W'(LAT + OUT_W - 1);
  localparam logic [CNT_W-1:0] COL_MAX     = CNT_W'(LAT + OUT_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [WC_W-1:0]   w_cnt_q, w_cnt_d;
  logic [CNT_W-1:0]  col_cnt_q, col_cnt_d;
  logic              filt_wr_q, filt_wr_d;
  logic [1:0]        filt_idx_q, filt_idx_d;
  logic [11:0]       filt_data_q, filt_data_d;
  logic              tag_q, tag_d;
  logic              m_valid_q, m_valid_d;
  logic [13:0]       m_data_q, m_data_d;

  logic stall, in_run, in_drain, w_acc, capture, done_cond;

  always_comb begin
    in_run    = (state_q == S_RUN);
    in_drain  = (state_q == S_DRAIN);
    stall     = m_valid_q & ~m_ready;
    busy      = (state_q != S_IDLE);
    w_ready   = rst_n & (state_q == S_LOAD_W) & (w_cnt_q != W_LAST);
    s_ready   = rst_n & in_run & ~stall;
    pe_en     = rst_n & ~stall & ((in_run & s_valid) | in_drain);
    pe_ifmap  = in_run ? s_data : 8'd0;
    w_acc     = w_valid & w_ready;
    // A tagged psum waits in the frozen chain until the output register can take it.
    capture   = tag_q & ~stall;
    done_cond = (state_q == S_DONE) & ~m_valid_q & ~tag_q;
    done      = rst_n & done_cond;
  end

  always_comb begin
    state_d     = state_q;
    w_cnt_d     = w_cnt_q;
    col_cnt_d   = col_cnt_q;
    filt_wr_d   = 1'b0;
    filt_idx_d  = filt_idx_q;
    filt_data_d = filt_data_q;
    tag_d       = tag_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;

    if (pe_en && col_cnt_q != COL_MAX) col_cnt_d = col_cnt_q + CNT_W'(1);

    if (pe_en)        tag_d = (col_cnt_q >= COL_FIRST) && (col_cnt_q <= COL_LAST);
    else if (capture) tag_d = 1'b0;

    if (capture) begin
      m_data_d  = psum_in;
      m_valid_d = 1'b1;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    if (w_acc) begin
      filt_data_d = w_data;
      filt_idx_d  = 2'(w_cnt_q);
      filt_wr_d   = 1'b1;
      w_cnt_d     = w_cnt_q + WC_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD_W;
          w_cnt_d   = '0;
          col_cnt_d = '0;
        end
      end
      S_LOAD_W: if (w_cnt_q == W_LAST && filt_wr_q) state_d = S_RUN;
      S_RUN:    if (pe_en && col_cnt_q == COL_LAST_IN) state_d = S_DRAIN;
      S_DRAIN:  if (pe_en && col_cnt_q == COL_LAST) state_d = S_DONE;
      S_DONE:   if (done_cond) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      w_cnt_q     <= '0;
      col_cnt_q   <= '0;
      filt_wr_q   <= 1'b0;
      filt_idx_q  <= '0;
      filt_data_q <= '0;
      tag_q       <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      w_cnt_q     <= w_cnt_d;
      col_cnt_q   <= col_cnt_d;
      filt_wr_q   <= filt_wr_d;
      filt_idx_q  <= filt_idx_d;
      filt_data_q <= filt_data_d;
      tag_q       <= tag_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
    end
  end

  assign filt_wr   = filt_wr_q;
  assign filt_idx  = filt_idx_q;
  assign filt_data = filt_data_q;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;

`ifdef CONV2_PE_CTRL_PERF_EN
  logic [15:0] perf_cycles_q, perf_stalls_q;

  always_ff @(posedge clk) begin
    if (!rst_n || (state_q == S_IDLE && start)) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (busy && perf_cycles_q != 16'hFFFF) perf_cycles_q <= perf_cycles_q + 16'd1;
      if ((in_run || in_drain) && !pe_en && perf_stalls_q != 16'hFFFF)
        perf_stalls_q <= perf_stalls_q + 16'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_conv2_pe_ctrl.sv
// Directed bench for conv2_pe_ctrl: a stub PE chain feeds psum_in, a sequence model predicts every result.
module tb_conv2_pe_ctrl;
  localparam int IFMAP_W = 28;
  localparam int LAT     = 4;
  localparam int OUT_W   = 26;
  localparam int N_EN    = 30;

  logic        clk = 1'b0;
  logic        rst_n, start, busy, done;
  logic        w_valid, w_ready, filt_wr;
  logic [11:0] w_data, filt_data;
  logic [1:0]  filt_idx;
  logic        s_valid, s_ready, pe_en;
  logic [7:0]  s_data, pe_ifmap;
  logic [13:0] psum_q, m_data;
  logic        m_valid, m_ready;
`ifdef CONV2_PE_CTRL_PERF_EN
  logic [15:0] perf_cycles, perf_stalls;
`endif

  always #5 clk = ~clk;

  conv2_pe_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .filt_wr(filt_wr), .filt_idx(filt_idx), .filt_data(filt_data),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .pe_en(pe_en), .pe_ifmap(pe_ifmap), .psum_in(psum_q),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready)
`ifdef CONV2_PE_CTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
  );

  // Stub last-PE psum register: history-dependent so any skipped/extra enable changes values.
  always @(posedge clk) begin
    if (!busy)      psum_q <= 14'd0;
    else if (pe_en) psum_q <= 14'(32'd3 * 32'(psum_q) + 32'(pe_ifmap));
  end

  int checks = 0, failures = 0;
  int xseq[N_EN];
  int exp_res[OUT_W];
  int res_log[OUT_W];
  logic [11:0] words[3];

  int job_id = 0, seen_job = 0;
  int res_cnt, en_cnt, fw_cnt, done_cnt, w_acc_cnt, s_acc_cnt;
  bit prev_stall = 1'b0;
  logic [13:0] prev_data;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, req, $time);
    end
  endtask

  // Compare process: every negedge, against the model and the handshake rules.
  always @(negedge clk) begin
    if (job_id != seen_job) begin
      res_cnt = 0; en_cnt = 0; fw_cnt = 0; done_cnt = 0; w_acc_cnt = 0; s_acc_cnt = 0;
      seen_job = job_id;
    end
    if (rst_n) begin
      if (prev_stall) begin
        chk("hold_m_valid", int'(m_valid), 1);
        chk("hold_m_data", int'(m_data), int'(prev_data));
      end
      if (m_valid && !m_ready) begin
        chk("stall_pe_en", int'(pe_en), 0);
        chk("stall_s_ready", int'(s_ready), 0);
      end
      if (m_valid && m_ready) begin
        if (res_cnt < OUT_W) begin
          chk("result", int'(m_data), exp_res[res_cnt]);
          res_log[res_cnt] = int'(m_data);
        end else chk("extra_result", res_cnt, OUT_W - 1);
        res_cnt++;
      end
      if (pe_en) begin
        if (en_cnt < N_EN) chk("pe_ifmap", int'(pe_ifmap), xseq[en_cnt]);
        else chk("extra_pe_en", en_cnt, N_EN - 1);
        en_cnt++;
      end
      if (!busy) chk("idle_pe_ifmap", int'(pe_ifmap), 0);
      if (s_ready) chk("run_after_last_wr", fw_cnt, 3);
      if (filt_wr) begin
        if (fw_cnt < 3) begin
          chk("filt_idx", int'(filt_idx), fw_cnt);
          chk("filt_data", int'(filt_data), int'(words[fw_cnt]));
        end else chk("extra_filt_wr", fw_cnt, 2);
        fw_cnt++;
      end
      if (done) begin
        chk("done_after_results", res_cnt, OUT_W);
        chk("done_m_valid", int'(m_valid), 0);
        done_cnt++;
      end
      if (w_valid && w_ready) w_acc_cnt++;
      if (s_valid && s_ready) s_acc_cnt++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic run_job(input bit s_gap, input bit hold, input bit w_gap, input int rst_at,
                         input bit noise);
    int cyc, hold_left, gap_left;
    bit hold_done, noise_done, was_reset;
    hold_left = 0; gap_left = 3; hold_done = 0; noise_done = 0; was_reset = 0;
    job_id++;
    @(posedge clk); #1;
    start = 1'b1; w_valid = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    for (cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      if (cyc > 2 && !busy) break;
      start = 1'b0;
      if (noise && s_acc_cnt == 5 && !noise_done) begin start = 1'b1; noise_done = 1; end
      if (noise && en_cnt == N_EN) start = 1'b1;
      if (w_gap && w_acc_cnt == 1 && gap_left > 0) begin
        w_valid = 1'b0; gap_left--;
      end else begin
        w_valid = (w_acc_cnt < 3);
        w_data  = words[(w_acc_cnt < 3) ? w_acc_cnt : 0];
      end
      s_valid = (s_acc_cnt < IFMAP_W) && (!s_gap || (cyc % 2 == 1));
      s_data  = 8'(s_acc_cnt + 1);
      if (hold && res_cnt == 3 && !hold_done) begin hold_left = 5; hold_done = 1; end
      m_ready = (hold_left == 0);
      if (hold_left > 0) hold_left--;
      if (rst_at > 0 && s_acc_cnt == rst_at) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; s_valid = 1'b0; w_valid = 1'b0; m_ready = 1'b1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_pe_en", int'(pe_en), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_no_done_pulse", done_cnt, 0);
        was_reset = 1;
        break;
      end
    end
    start = 1'b0; s_valid = 1'b0; w_valid = 1'b0; m_ready = 1'b1;
    if (cyc >= 600) chk("job_timeout_busy", int'(busy), 0);
    if (!was_reset) begin
      chk("results", res_cnt, OUT_W);
      chk("pe_en_total", en_cnt, N_EN);
      chk("done_pulses", done_cnt, 1);
      chk("filt_wr_count", fw_cnt, 3);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_job", int'(busy), 0);
    $display("job %0d sgap=%0d hold=%0d wgap=%0d rst_at=%0d noise=%0d: results=%0d pe_en=%0d done=%0d",
             job_id, s_gap, hold, w_gap, rst_at, noise, res_cnt, en_cnt, done_cnt);
  endtask

  initial begin
    int p;
    rst_n = 1'b0; start = 1'b0; w_valid = 1'b0; w_data = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    words[0] = 12'h321; words[1] = 12'h654; words[2] = 12'h987;
    for (int n = 0; n < N_EN; n++) xseq[n] = (n < IFMAP_W) ? n + 1 : 0;
    // Result k is the psum after the (LAT+k+1)-th enable of the chain.
    p = 0;
    for (int n = 1; n <= N_EN; n++) begin
      p = (3 * p + xseq[n-1]) & 32'h3FFF;
      if (n > LAT) exp_res[n - LAT - 1] = p;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_w_ready", int'(w_ready), 0);
    chk("reset_s_ready", int'(s_ready), 0);
    chk("reset_m_valid", int'(m_valid), 0);
    chk("reset_filt_wr", int'(filt_wr), 0);
    chk("reset_m_data", int'(m_data), 0);
    rst_n = 1'b1;

    run_job(0, 0, 0, 0, 0);
    chk("lit_result0", res_log[0], 179);
    chk("lit_result1", res_log[1], 543);
    run_job(1, 0, 0, 0, 0);
    chk("gap_lit_result0", res_log[0], 179);
    run_job(0, 1, 0, 0, 0);
    run_job(0, 0, 1, 0, 0);
    run_job(0, 0, 0, 10, 0);
    run_job(0, 0, 0, 0, 0);
    run_job(0, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
